// File: rtl/uart_pkg.sv
// Shared definitions for the UART control path: FSM state codes, frame
// delimiter defaults, the source byte payload and the frame checksum.
package uart_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HEAD = 3'd1;
  localparam logic [2:0] ST_ID   = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_SUM  = 3'd4;
  localparam logic [2:0] ST_TAIL = 3'd5;

  localparam logic [7:0] UART_HEAD = 8'h55;
  localparam logic [7:0] UART_TAIL = 8'hAA;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } src_byte_t;

  // Two's complement of id + payload sum, so id + payload + checksum == 0 mod 256.
  function automatic logic [7:0] uart_checksum(input logic [7:0] id, input logic [7:0] sum);
    logic [7:0] total;
    total = id + sum;
    return 8'(~total + 8'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer,
// and moves the pointer just past the winner when advance is strobed.
module rr_arbiter #(
  parameter int unsigned N_SRC = 4,
  localparam int unsigned IW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req,
  input  logic             advance,
  output logic [N_SRC-1:0] grant_c,
  output logic [IW-1:0]    grant_idx_c,
  output logic             any_c
);

  logic [IW-1:0] ptr;

  // Upward scan from the pointer with wrap-around.
  always_comb begin
    logic [IW-1:0] idx;
    grant_c     = '0;
    grant_idx_c = '0;
    any_c       = 1'b0;
    idx         = '0;
    for (int unsigned off = 0; off < N_SRC; off++) begin
      idx = IW'((32'(ptr) + off) % N_SRC);
      if (!any_c && req[idx]) begin
        any_c        = 1'b1;
        grant_c[idx] = 1'b1;
        grant_idx_c  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && any_c) begin
      ptr <= IW'((32'(grant_idx_c) + 1) % N_SRC);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_SRC frame sources; wraps each granted
// payload as HEAD, id, payload, checksum, TAIL over the Tx_en/Tx_ACK handshake.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 50000,
  parameter logic [7:0]  HEAD    = UART_HEAD,
  parameter logic [7:0]  TAIL    = UART_TAIL
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_SRC-1:0]   i_src_req,
  input  logic [N_SRC-1:0]   i_src_valid,
  input  logic [N_SRC-1:0]   i_src_last,
  input  logic [8*N_SRC-1:0] i_src_data,
  output logic [N_SRC-1:0]   o_src_ready,
  output logic [N_SRC-1:0]   o_src_done,
  output logic [N_SRC-1:0]   o_grant,
  input  logic               i_tx_ack,
  output logic               o_tx_en,
  output logic [7:0]         o_tx_data,
  output logic               o_busy,
  output logic               o_err_timeout
);

  localparam int unsigned IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [2:0]       state, state_d;
  logic [IW-1:0]    grant_idx, grant_idx_d;
  logic             held, held_d;
  logic             held_last, held_last_d;
  logic [7:0]       sum, sum_d, sum_acc;
  logic [CW-1:0]    count, count_d, count_inc;
  logic [TW-1:0]    tmo, tmo_d;
  logic [N_SRC-1:0] grant_d, ready_d, done_d;
  logic             tx_en_d, busy_d, err_d;
  logic [7:0]       tx_data_d;
  logic             ack, advance;
  logic [N_SRC-1:0] arb_grant_c;
  logic [IW-1:0]    arb_idx_c;
  logic             arb_any_c;
  src_byte_t        sel_byte;
  logic             sel_valid;
  logic [7:0]       id8;

  rr_arbiter #(.N_SRC(N_SRC)) u_arb (
    .clk         (i_clk),
    .rst_n       (i_rst),
    .req         (i_src_req),
    .advance     (advance),
    .grant_c     (arb_grant_c),
    .grant_idx_c (arb_idx_c),
    .any_c       (arb_any_c)
  );

  // Byte stream of the current owner, selected by the one-hot grant.
  always_comb begin
    sel_valid = 1'b0;
    sel_byte  = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (o_grant[k]) begin
        sel_valid     = i_src_valid[k];
        sel_byte.data = i_src_data[8*k +: 8];
        sel_byte.last = i_src_last[k];
      end
    end
  end

  assign ack       = i_tx_ack & o_tx_en;
  assign id8       = 8'(grant_idx);
  assign sum_acc   = sum + o_tx_data;
  assign count_inc = count + CW'(1);

  always_comb begin
    state_d     = state;
    grant_d     = o_grant;
    grant_idx_d = grant_idx;
    held_d      = held;
    held_last_d = held_last;
    sum_d       = sum;
    count_d     = count;
    tmo_d       = tmo;
    tx_en_d     = o_tx_en;
    tx_data_d   = o_tx_data;
    busy_d      = o_busy;
    ready_d     = '0;
    done_d      = '0;
    err_d       = 1'b0;
    advance     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_any_c) begin
          advance     = 1'b1;
          state_d     = ST_HEAD;
          grant_d     = arb_grant_c;
          grant_idx_d = arb_idx_c;
          held_d      = 1'b0;
          sum_d       = '0;
          count_d     = '0;
          tmo_d       = '0;
          busy_d      = 1'b1;
          tx_en_d     = 1'b1;
          tx_data_d   = HEAD;
        end
      end
      ST_HEAD: begin
        if (ack) begin
          state_d   = ST_ID;
          tx_data_d = id8;
        end
      end
      ST_ID: begin
        if (ack) begin
          state_d = ST_DATA;
          tx_en_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (held) begin
          if (ack) begin
            sum_d   = sum_acc;
            count_d = count_inc;
            held_d  = 1'b0;
            if (held_last || count_inc == CW'(MAX_LEN)) begin
              state_d   = ST_SUM;
              tx_data_d = uart_checksum(id8, sum_acc);
            end else begin
              tx_en_d = 1'b0;
            end
          end
        end else if (sel_valid) begin
          held_d      = 1'b1;
          held_last_d = sel_byte.last;
          tx_data_d   = sel_byte.data;
          tx_en_d     = 1'b1;
          ready_d     = o_grant;
          tmo_d       = '0;
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          // Stalled source: close the frame with a deliberately wrong checksum.
          err_d     = 1'b1;
          state_d   = ST_SUM;
          tx_en_d   = 1'b1;
          tx_data_d = ~uart_checksum(id8, sum);
          tmo_d     = '0;
        end else begin
          tmo_d = tmo + TW'(1);
        end
      end
      ST_SUM: begin
        if (ack) begin
          state_d   = ST_TAIL;
          tx_data_d = TAIL;
        end
      end
      ST_TAIL: begin
        if (ack) begin
          state_d   = ST_IDLE;
          done_d    = o_grant;
          grant_d   = '0;
          busy_d    = 1'b0;
          tx_en_d   = 1'b0;
          tx_data_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state         <= ST_IDLE;
      grant_idx     <= '0;
      held          <= 1'b0;
      held_last     <= 1'b0;
      sum           <= '0;
      count         <= '0;
      tmo           <= '0;
      o_grant       <= '0;
      o_src_ready   <= '0;
      o_src_done    <= '0;
      o_tx_en       <= 1'b0;
      o_tx_data     <= '0;
      o_busy        <= 1'b0;
      o_err_timeout <= 1'b0;
    end else begin
      state         <= state_d;
      grant_idx     <= grant_idx_d;
      held          <= held_d;
      held_last     <= held_last_d;
      sum           <= sum_d;
      count         <= count_d;
      tmo           <= tmo_d;
      o_grant       <= grant_d;
      o_src_ready   <= ready_d;
      o_src_done    <= done_d;
      o_tx_en       <= tx_en_d;
      o_tx_data     <= tx_data_d;
      o_busy        <= busy_d;
      o_err_timeout <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based source models, a UART driver model
// with random ack latency, and a frame-level reference built from the rules.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int ML  = 16;
  localparam int TMO = 100;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, valid, last;
  logic [8*N-1:0] data;
  logic           tx_ack;
  logic [N-1:0]   src_ready, src_done, grant;
  logic           tx_en, busy, err_timeout;
  logic [7:0]     tx_data;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_SRC(N), .MAX_LEN(ML), .TIMEOUT(TMO)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_src_req     (req),
    .i_src_valid   (valid),
    .i_src_last    (last),
    .i_src_data    (data),
    .o_src_ready   (src_ready),
    .o_src_done    (src_done),
    .o_grant       (grant),
    .i_tx_ack      (tx_ack),
    .o_tx_en       (tx_en),
    .o_tx_data     (tx_data),
    .o_busy        (busy),
    .o_err_timeout (err_timeout)
  );

  int checks = 0, failures = 0;
  int cyc = 0, last_ack_cyc = 0;
  logic [7:0] src_q [N][$];
  bit         last_q [N][$];
  int         pending [N];
  int         ptr_m, cur_g, exp_n, ready_cnt, err_cnt, frames_done;
  bit         exp_tmo;
  logic [7:0] exp_q[$], cap_q[$], last_frame[$];
  int         grant_log[$];
  logic       tx_en_prev;
  logic [7:0] tx_data_prev;
  logic [N-1:0] grant_prev;
  int         wait_cnt, cur_delay, ack_fixed;
  bit         spur_en;
  logic [7:0] exp1 [7];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int total_pending();
    int t = 0;
    for (int k = 0; k < N; k++) t += pending[k];
    return t;
  endfunction

  function automatic int idx_of(input logic [N-1:0] oh);
    for (int k = 0; k < N; k++) if (oh[k]) return k;
    return -1;
  endfunction

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int off = 0; off < N; off++) if (r[(p + off) % N]) return (p + off) % N;
    return -1;
  endfunction

  // Expected frame from the source's queued bytes at grant time.
  task automatic build_expected(input int g);
    int s, n, c;
    exp_q.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'(g));
    s = g; n = 0; exp_tmo = 1'b1;
    for (int i = 0; i < src_q[g].size(); i++) begin
      exp_q.push_back(src_q[g][i]);
      s += int'(src_q[g][i]);
      n++;
      if (last_q[g][i] || n == ML) begin
        exp_tmo = 1'b0;
        break;
      end
    end
    c = (256 - (s % 256)) % 256;
    if (exp_tmo) c = c ^ 255;
    exp_q.push_back(8'(c));
    exp_q.push_back(8'hAA);
    exp_n = n;
  endtask

  task automatic monitor();
    logic ack_taken;
    int   g;
    ack_taken = tx_ack && tx_en_prev;
    if (ack_taken) begin
      cap_q.push_back(tx_data_prev);
      last_ack_cyc = cyc;
    end
    if (tx_en_prev && !ack_taken) begin
      check("tx_en_hold", 32'(tx_en), 32'd1);
      check("tx_data_hold", 32'(tx_data), 32'(tx_data_prev));
    end
    if (grant != '0 && grant_prev == '0) begin
      g = rr_pick(req, ptr_m);
      check("grant", 32'(grant), (g >= 0) ? 32'(1 << g) : 32'd0);
      check("busy_set", 32'(busy), 32'd1);
      cur_g = idx_of(grant);
      grant_log.push_back(cur_g);
      if (cur_g >= 0) begin
        build_expected(cur_g);
        ptr_m = (cur_g + 1) % N;
      end
      cap_q.delete();
      ready_cnt = 0;
      err_cnt   = 0;
    end
    if (src_ready != '0) begin
      check("ready_owner", 32'(src_ready), 32'(grant));
      ready_cnt++;
      if (cur_g >= 0 && src_q[cur_g].size() > 0) begin
        void'(src_q[cur_g].pop_front());
        void'(last_q[cur_g].pop_front());
      end
    end
    if (err_timeout) begin
      err_cnt++;
      check("tmo_latency", 32'(cyc - last_ack_cyc), 32'(TMO));
    end
    if (src_done != '0) begin
      check("done_owner", 32'(src_done), 32'(grant_prev));
      check("grant_clear", 32'(grant), 32'd0);
      check("busy_clear", 32'(busy), 32'd0);
      check("frame_len", 32'(cap_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
        check($sformatf("frame_byte%0d", i), 32'(cap_q[i]), 32'(exp_q[i]));
      check("ready_cnt", 32'(ready_cnt), 32'(exp_n));
      check("err_cnt", 32'(err_cnt), 32'(exp_tmo));
      if (cur_g >= 0 && pending[cur_g] > 0) pending[cur_g]--;
      frames_done++;
      last_frame = cap_q;
    end
    tx_en_prev   = tx_en;
    tx_data_prev = tx_data;
    grant_prev   = grant;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req[k]   = pending[k] > 0;
      valid[k] = src_q[k].size() > 0;
      data[8*k +: 8] = (src_q[k].size() > 0) ? src_q[k][0] : 8'h00;
      last[k]  = (last_q[k].size() > 0) ? last_q[k][0] : 1'b0;
    end
    tx_ack = 1'b0;
    if (tx_en) begin
      if (wait_cnt >= cur_delay) begin
        tx_ack    = 1'b1;
        wait_cnt  = 0;
        cur_delay = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 5));
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      if (spur_en && $urandom_range(0, 3) == 0) tx_ack = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    monitor();
    drive();
  endtask

  task automatic do_reset();
    for (int k = 0; k < N; k++) begin
      src_q[k].delete();
      last_q[k].delete();
      pending[k] = 0;
    end
    req = '0; valid = '0; last = '0; data = '0; tx_ack = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    check("rst_outs", 32'({src_ready, src_done, grant, tx_en, tx_data, busy, err_timeout}), 32'd0);
    rst = 1'b1;
    ptr_m = 0; cur_g = -1; grant_prev = '0; tx_en_prev = 1'b0; tx_data_prev = '0;
    wait_cnt = 0; cap_q.delete();
  endtask

  task automatic run_drain(input int budget);
    int n = 0;
    drive();
    while ((total_pending() > 0 || busy) && n < budget) begin
      step();
      n++;
    end
    check("drain_pending", 32'(total_pending()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic push_frame(input int g, input int len, input bit with_last);
    for (int i = 0; i < len; i++) begin
      src_q[g].push_back(8'($urandom_range(0, 255)));
      last_q[g].push_back(with_last && (i == len - 1));
    end
    pending[g]++;
  endtask

  initial begin
    int n, fd0, total;
    rst = 1'b0; req = '0; valid = '0; last = '0; data = '0; tx_ack = 1'b0;
    ack_fixed = -1; spur_en = 1'b0; cur_delay = 0; frames_done = 0;
    exp1 = '{8'h55, 8'h02, 8'h11, 8'h22, 8'h33, 8'h98, 8'hAA};
    do_reset();

    // Acks while idle must not start anything.
    spur_en = 1'b1;
    drive();
    repeat (12) begin
      step();
      check("idle_quiet", 32'({busy, tx_en, grant}), 32'd0);
    end

    // Single source 2, fixed ack latency.
    spur_en = 1'b0; ack_fixed = 3; cur_delay = 3;
    src_q[2] = '{8'h11, 8'h22, 8'h33};
    last_q[2] = '{1'b0, 1'b0, 1'b1};
    pending[2] = 1;
    fd0 = frames_done;
    run_drain(500);
    check("t1_frames", 32'(frames_done - fd0), 32'd1);
    check("t1_ready", 32'(ready_cnt), 32'd3);
    check("t1_len", 32'(last_frame.size()), 32'd7);
    for (int i = 0; i < 7 && i < last_frame.size(); i++)
      check($sformatf("t1_byte%0d", i), 32'(last_frame[i]), 32'(exp1[i]));

    // Round-robin with all sources requesting.
    do_reset();
    ack_fixed = -1; spur_en = 1'b1; grant_log.delete();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) push_frame(k, 1, 1'b1);
    run_drain(3000);
    check("rr_count", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check($sformatf("rr_order%0d", i), 32'(grant_log[i]), 32'(i % N));

    // Payload limit: 20 bytes offered, no last.
    push_frame(0, 20, 1'b0);
    run_drain(3000);
    check("ml_len", 32'(last_frame.size()), 32'(ML + 4));
    check("ml_left", 32'(src_q[0].size()), 32'd4);
    total = 0;
    for (int i = 1; i < last_frame.size() - 1; i++) total += int'(last_frame[i]);
    check("ml_sum_zero", 32'(total % 256), 32'd0);
    src_q[0].delete(); last_q[0].delete();

    // Timeout: one byte then the source stalls.
    src_q[1].push_back(8'hFE); last_q[1].push_back(1'b0); pending[1] = 1;
    run_drain(2000);
    check("tmo_len", 32'(last_frame.size()), 32'd5);
    check("tmo_sum", (last_frame.size() > 3) ? 32'(last_frame[3]) : 32'hFFFF, 32'hFE);
    check("tmo_tail", (last_frame.size() > 4) ? 32'(last_frame[4]) : 32'hFFFF, 32'hAA);
    check("tmo_err", 32'(err_cnt), 32'd1);

    // Reset in the middle of a frame, during its second byte.
    ack_fixed = 3; spur_en = 1'b0;
    push_frame(2, 5, 1'b1);
    drive();
    n = 0;
    while (ready_cnt < 2 && n < 300) begin
      step();
      n++;
    end
    check("rst_mid_reached", 32'(ready_cnt), 32'd2);
    fd0 = frames_done;
    do_reset();
    drive();
    step();
    check("rst_no_done", 32'({src_done, busy, tx_en}), 32'd0);
    grant_log.delete();
    push_frame(3, 3, 1'b1);
    push_frame(1, 2, 1'b1);
    run_drain(1000);
    check("rst_first_grant", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFF, 32'd1);
    check("rst_second_grant", (grant_log.size() > 1) ? 32'(grant_log[1]) : 32'hFF, 32'd3);
    check("rst_head", (last_frame.size() > 1) ? 32'(last_frame[0]) : 32'hFFFF, 32'h55);
    check("rst_id", (last_frame.size() > 1) ? 32'(last_frame[1]) : 32'hFFFF, 32'h03);
    check("rst_frames", 32'(frames_done - fd0), 32'd2);

    // Randomized traffic with spurious acks and random ack latency.
    ack_fixed = -1; spur_en = 1'b1;
    fd0 = frames_done;
    for (int f = 0; f < 40; f++)
      push_frame(int'($urandom_range(0, N - 1)), int'($urandom_range(1, ML)), 1'b1);
    run_drain(30000);
    check("rand_frames", 32'(frames_done - fd0), 32'd40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
